// File: rtl/sd_pkg.sv
// Shared defaults and helpers for the programmable serial sequence detector.
// Defaults reproduce the legacy 101010 non-overlapping detector.
package sd_pkg;

   localparam int unsigned SD_MAX_LEN     = 8;
   localparam int unsigned SD_LEN_W       = 4;
   localparam int unsigned SD_CNT_W       = 8;
   localparam logic [7:0]  SD_DEF_PATTERN = 8'b0010_1010;
   localparam int unsigned SD_DEF_LEN     = 6;
   localparam bit          SD_DEF_OVERLAP = 1'b0;

   function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/sd_match_core.sv
// History shift register, fill counter and length-masked pattern compare.
// match_o is combinational and only asserted on a cycle that shifts a bit in.
module sd_match_core #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               shift_i,
   input  logic               clear_i,
   input  logic               n_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic               overlap_i,
   output logic               match_o
);

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W:0]     fill_q, fill_d;

   always_comb begin
      cand = {hist_q[MAX_LEN-2:0], n_i};
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < 32'(len_i));
      end
      // fill+1 counts the incoming bit; bits above len are masked out of the compare
      match_o = shift_i && ((fill_q + (LEN_W+1)'(1)) >= {1'b0, len_i}) &&
                (((cand ^ pattern_i) & mask) == '0);
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clear_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift_i) begin
         hist_d = cand;
         if (match_o && !overlap_i) begin
            fill_d = '0;
         end else if (fill_q != (LEN_W+1)'(MAX_LEN)) begin
            fill_d = fill_q + (LEN_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/sd_prog.sv
// Run-time programmable serial sequence detector: config registers,
// registered match pulse, saturating match counter and config-error pulse.
module sd_prog
   import sd_pkg::*;
#(
   parameter int unsigned          MAX_LEN     = SD_MAX_LEN,
   parameter int unsigned          LEN_W       = SD_LEN_W,
   parameter int unsigned          CNT_W       = SD_CNT_W,
   parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(SD_DEF_PATTERN),
   parameter int unsigned          DEF_LEN     = SD_DEF_LEN,
   parameter bit                   DEF_OVERLAP = SD_DEF_OVERLAP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               n,
   input  logic               n_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               op,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic               op_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q;
   logic               cfg_ok;
   logic               shift;
   logic               match;

   // Any cfg_load, legal or not, swallows the serial bit of that cycle
   assign cfg_ok = cfg_load && len_legal(32'(cfg_len), MAX_LEN);
   assign shift  = n_valid && !cfg_load;

   sd_match_core #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .shift_i   (shift),
      .clear_i   (cfg_ok),
      .n_i       (n),
      .pattern_i (pattern_q),
      .len_i     (len_q),
      .overlap_i (overlap_q),
      .match_o   (match)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = match ? CNT_W'(1) : '0;
      end else if (match && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern_q <= DEF_PATTERN;
         len_q     <= LEN_W'(DEF_LEN);
         overlap_q <= DEF_OVERLAP;
         op_q      <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         if (cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
         end
         op_q  <= match;
         cnt_q <= cnt_d;
         err_q <= cfg_load && !cfg_ok;
      end
   end

   assign op        = op_q;
   assign match_cnt = cnt_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_sd_prog.sv
// Directed bench for sd_prog: a queue-based model of the detection rules is
// checked every cycle, plus hand-computed pulse counts and counter values.
module tb_sd_prog;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               n = 1'b0;
   logic               n_valid = 1'b0;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               cnt_clr = 1'b0;
   logic               op;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err;

   sd_prog #(
      .MAX_LEN     (MAX_LEN),
      .LEN_W       (LEN_W),
      .CNT_W       (CNT_W),
      .DEF_PATTERN (8'b0010_1010),
      .DEF_LEN     (6),
      .DEF_OVERLAP (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .n           (n),
      .n_valid     (n_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .op          (op),
      .match_cnt   (match_cnt),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int op_seen     = 0;

   // Model: bits received (newest at back), bits since last clear, config, outputs
   bit         mq[$];
   int         m_fill;
   int         m_len;
   logic [7:0] m_pat;
   bit         m_ovl;
   bit         e_op;
   bit         e_err;
   int         e_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pat  = 8'h2A;
      m_len  = 6;
      m_ovl  = 1'b0;
      mq.delete();
      m_fill = 0;
      e_op   = 1'b0;
      e_err  = 1'b0;
      e_cnt  = 0;
   endtask

   task automatic model_step();
      bit m;
      m     = 1'b0;
      e_err = 1'b0;
      if (cfg_load) begin
         if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
            m_pat  = cfg_pattern;
            m_len  = int'(cfg_len);
            m_ovl  = cfg_overlap;
            mq.delete();
            m_fill = 0;
         end else begin
            e_err = 1'b1;
         end
      end else if (n_valid) begin
         mq.push_back(n);
         if (mq.size() > MAX_LEN) void'(mq.pop_front());
         if (m_fill < MAX_LEN) m_fill++;
         if (m_fill >= m_len) begin
            m = 1'b1;
            for (int i = 0; i < m_len; i++) begin
               if (mq[mq.size() - 1 - i] != m_pat[i]) m = 1'b0;
            end
         end
         if (m && !m_ovl) m_fill = 0;
      end
      e_op = m;
      if (cnt_clr) e_cnt = m ? 1 : 0;
      else if (m && e_cnt < CNT_MAX) e_cnt++;
   endtask

   task automatic check_outputs();
      check("op", 32'(op), 32'(e_op));
      check("match_cnt", 32'(match_cnt), 32'(e_cnt));
      check("cfg_err", 32'(cfg_err), 32'(e_err));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
      if (op === 1'b1) op_seen++;
   endtask

   task automatic idle();
      n_valid  = 1'b0;
      n        = 1'b0;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   // '0'/'1' shift a bit, '_' is an n_valid=0 gap
   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         n_valid = (s[i] != "_");
         n       = (s[i] == "1");
         tick();
      end
      idle();
   endtask

   task automatic load_cfg(input logic [7:0] pat, input int len, input bit ovl,
                           input bit nv, input bit nb);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = LEN_W'(len);
      cfg_overlap = ovl;
      n_valid     = nv;
      n           = nb;
      tick();
      idle();
   endtask

   task automatic async_reset(input string name);
      #2 rst = 1'b0;
      model_reset();
      #1;
      check_outputs();
      check({name, "_op"}, 32'(op), 0);
      check({name, "_cnt"}, 32'(match_cnt), 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      idle();
      async_reset("por");

      // Defaults: 101010 non-overlapping
      op_seen = 0;
      send("1010101010");
      check("def_ops", 32'(op_seen), 1);
      check("def_cnt", 32'(match_cnt), 1);

      cnt_clr = 1'b1;
      tick();
      idle();
      check("clr_cnt", 32'(match_cnt), 0);

      // Overlapping 101010
      load_cfg(8'h2A, 6, 1'b1, 1'b0, 1'b0);
      op_seen = 0;
      send("1010101010");
      check("ovl_ops", 32'(op_seen), 3);
      check("ovl_cnt", 32'(match_cnt), 3);

      // Two more matches: counter saturates at 3
      send("1010");
      check("sat_ops", 32'(op_seen), 5);
      check("sat_cnt", 32'(match_cnt), 3);

      // cnt_clr coincident with a match
      send("1");
      n_valid = 1'b1;
      n       = 1'b0;
      cnt_clr = 1'b1;
      tick();
      idle();
      check("clr_match_op", 32'(op), 1);
      check("clr_match_cnt", 32'(match_cnt), 1);

      // Illegal length 0: bit 1 discarded, config kept (0x2A/6, overlap)
      load_cfg(8'h03, 0, 1'b0, 1'b1, 1'b1);
      check("err_len0", 32'(cfg_err), 1);
      tick();
      check("err_one_cycle", 32'(cfg_err), 0);
      op_seen = 0;
      send("10");
      check("err_hist_kept", 32'(op_seen), 1);

      load_cfg(8'hFF, 9, 1'b0, 1'b0, 1'b0);
      check("err_len9", 32'(cfg_err), 1);

      // Reprogram 011, len 3, non-overlap, with gaps inside the pattern
      load_cfg(8'h03, 3, 1'b0, 1'b1, 1'b1);
      check("load_no_err", 32'(cfg_err), 0);
      op_seen = 0;
      send("0_11_0__110");
      check("rep_ops", 32'(op_seen), 2);

      // Length 1: every 1 matches
      load_cfg(8'h01, 1, 1'b0, 1'b0, 1'b0);
      op_seen = 0;
      send("11010");
      check("len1_ops", 32'(op_seen), 3);

      // Async reset mid-pattern drops partial history
      async_reset("rst_a");
      send("1010");
      async_reset("rst_b");
      op_seen = 0;
      send("10101");
      check("rst_early_ops", 32'(op_seen), 0);
      send("0");
      check("rst_ops", 32'(op_seen), 1);
      check("rst_cnt", 32'(match_cnt), 1);

      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
